// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - pipelined byte-addressable data RAM with in-order, credit-controlled responses
module data_ram_ctrl #(
  parameter int DEPTH_WORDS  = 24576,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_mode,
  input  logic                  req_signed,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);
  localparam int MAW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int FDEPTH = READ_LATENCY + 1;
  localparam int PW     = $clog2(FDEPTH);
  localparam int CW     = $clog2(FDEPTH + 1);

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [1:0]  lane;
    logic [1:0]  mode;
    logic        sgn;
    logic        err;
    logic [31:0] word;
  } stage_t;

  logic [31:0]           mem [DEPTH_WORDS];
  stage_t                pipe [READ_LATENCY];
  stage_t                last;
  logic [32:0]           fifo [FDEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         occ, inflight;
  logic                  accept, push, pop, fault;
  logic [ADDR_WIDTH-1:0] widx_full;
  logic [MAW-1:0]        widx;
  logic [3:0]            be;
  logic [31:0]           wlanes, fmt_data;
  logic [7:0]            sel_b;
  logic [15:0]           sel_h;

  // Credits come only from registered counts, so a pop frees a slot one cycle later.
  assign req_ready = ({1'b0, inflight} + {1'b0, occ}) < (CW+1)'(FDEPTH);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (occ != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign last      = pipe[READ_LATENCY-1];
  assign push      = last.valid;
  assign widx_full = req_addr >> 2;
  assign widx      = widx_full[MAW-1:0];

  assign fault = (req_mode == 2'd3)
               | ((req_mode == 2'd1) & req_addr[0])
               | ((req_mode == 2'd2) & (req_addr[1:0] != 2'b00))
               | (widx_full >= ADDR_WIDTH'(DEPTH_WORDS));

  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_mode)
      2'd0: begin
        be     = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: accept, we: req_we, lane: req_addr[1:0], mode: req_mode,
                   sgn: req_signed, err: fault,
                   word: (accept && !req_we && !fault) ? mem[widx] : 32'h0};
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    sel_b    = last.word[{last.lane, 3'b000} +: 8];
    sel_h    = last.lane[1] ? last.word[31:16] : last.word[15:0];
    fmt_data = '0;
    if (!last.err && !last.we) begin
      case (last.mode)
        2'd0:    fmt_data = {{24{last.sgn & sel_b[7]}}, sel_b};
        2'd1:    fmt_data = {{16{last.sgn & sel_h[15]}}, sel_h};
        default: fmt_data = last.word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= {last.err, fmt_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      inflight <= '0;
    end else begin
      if (push) wptr <= (wptr == PW'(FDEPTH-1)) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == PW'(FDEPTH-1)) ? '0 : rptr + PW'(1);
      occ      <= occ + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(accept) - CW'(push);
    end
  end

  assign rsp_rdata = rsp_valid ? fifo[rptr][31:0] : 32'h0;
  assign rsp_err   = rsp_valid & fifo[rptr][32];

endmodule
